// File: rtl/pea_pkg.sv
// Shared constants and types for the PEA actor.
// Modes, opcodes, width helper and the token requirement bundle.
package pea_pkg;

  typedef enum logic [1:0] {
    SETUP_INSTR = 2'b00,
    INSTR       = 2'b01,
    OUTPUT      = 2'b10,
    MODE_RSV    = 2'b11
  } mode_e;

  localparam logic [7:0] STP = 8'h01;
  localparam logic [7:0] EVP = 8'h02;
  localparam logic [7:0] EVB = 8'h03;
  localparam logic [7:0] RST = 8'h04;
  localparam logic [7:0] HLT = 8'h05;

  localparam int REQ_W = 6;

  typedef struct packed {
    logic             mode_ok;
    logic             cmd;
    logic [REQ_W-1:0] data;
    logic [REQ_W-1:0] res;
    logic             stat;
  } tok_req_t;

  function automatic int pea_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << r) < 64'(v))
        r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pea_token_req.sv
// Maps mode, opcode and argument to the tokens and slots a firing needs.
// mode_ok low means the actor may not fire regardless of counts.
module pea_token_req
  import pea_pkg::*;
(
  input  logic [1:0] next_instr,
  input  logic [7:0] instr,
  input  logic [4:0] arg2,
  output tok_req_t   req
);

  logic [REQ_W-1:0] arg_z;
  logic [REQ_W-1:0] arg_p1;

  assign arg_z  = {1'b0, arg2};
  assign arg_p1 = arg_z + 6'd1;

  always_comb begin
    req = '0;
    unique case (next_instr)
      SETUP_INSTR: begin
        req.mode_ok = 1'b1;
        req.cmd     = 1'b1;
      end
      INSTR: begin
        req.mode_ok = 1'b1;
        unique case (instr)
          STP: req.data = arg_p1;
          EVP: req.data = 6'd1;
          EVB: begin
            req.data    = arg_z;
            // an empty block is never fireable
            req.mode_ok = (arg2 != 5'd0);
          end
          default: req.data = '0;
        endcase
      end
      OUTPUT: begin
        req.mode_ok = 1'b1;
        req.stat    = 1'b1;
        req.res     = (instr == EVB) ? arg_z : 6'd1;
      end
      default: req = '0;
    endcase
  end

endmodule

// File: rtl/pea_enable.sv
// Fireability check for the PEA actor.
// Compares token requirements with FIFO counts; registered output.
module pea_enable
  import pea_pkg::*;
#(
  parameter int BUFFER_SIZE     = 1024,
  parameter int BUFFER_SIZE_OUT = 32,
  parameter int CNT_W           = pea_log2(BUFFER_SIZE),
  parameter int OCNT_W          = pea_log2(BUFFER_SIZE_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  command_pop,
  input  logic [CNT_W-1:0]  data_pop,
  input  logic [OCNT_W-1:0] free_space_out_result,
  input  logic [OCNT_W-1:0] free_space_out_status,
  input  logic [1:0]        next_instr,
  input  logic [7:0]        instr,
  input  logic [4:0]        arg2,
  output logic              enable
);

  tok_req_t req;
  logic     cmd_ok;
  logic     data_ok;
  logic     res_ok;
  logic     stat_ok;
  logic     en_d;

  pea_token_req u_req (
    .next_instr (next_instr),
    .instr      (instr),
    .arg2       (arg2),
    .req        (req)
  );

  assign cmd_ok  = !req.cmd  || (command_pop != '0);
  assign stat_ok = !req.stat || (free_space_out_status != '0);
  assign data_ok = 32'(data_pop) >= 32'(req.data);
  assign res_ok  = 32'(free_space_out_result) >= 32'(req.res);

  assign en_d = req.mode_ok & cmd_ok & data_ok & res_ok & stat_ok;

  always_ff @(posedge clk) begin
    if (rst)
      enable <= 1'b0;
    else
      enable <= en_d;
  end

endmodule

// File: tb/tb_pea_enable.sv
// Directed bench for pea_enable.
// Expected values are hand-derived per vector.
module tb_pea_enable;

  logic       clk;
  logic       rst;
  logic [9:0] command_pop;
  logic [9:0] data_pop;
  logic [4:0] free_space_out_result;
  logic [4:0] free_space_out_status;
  logic [1:0] next_instr;
  logic [7:0] instr;
  logic [4:0] arg2;
  logic       enable;

  int n_chk;
  int n_pass;

  pea_enable dut (
    .clk                   (clk),
    .rst                   (rst),
    .command_pop           (command_pop),
    .data_pop              (data_pop),
    .free_space_out_result (free_space_out_result),
    .free_space_out_status (free_space_out_status),
    .next_instr            (next_instr),
    .instr                 (instr),
    .arg2                  (arg2),
    .enable                (enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk = n_chk + 1;
    if (obs === exp)
      n_pass = n_pass + 1;
    else
      $display("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    command_pop = 10'd5;
    data_pop = '0;
    free_space_out_result = '0;
    free_space_out_status = '0;
    next_instr = 2'b00;
    instr = 8'h00;
    arg2 = '0;

    cyc; chk("rst_c0", enable, 1'b0);
    cyc; chk("rst_c1", enable, 1'b0);
    rst = 1'b0;
    cyc; chk("rst_rel", enable, 1'b1);

    command_pop = 10'd0;
    #1 chk("latency", enable, 1'b1);
    cyc; chk("setup_empty", enable, 1'b0);
    command_pop = 10'd1;
    cyc; chk("setup_one", enable, 1'b1);

    next_instr = 2'b01;
    instr = 8'h01; arg2 = 5'd3; data_pop = 10'd3;
    cyc; chk("stp3_d3", enable, 1'b0);
    data_pop = 10'd4;
    cyc; chk("stp3_d4", enable, 1'b1);
    arg2 = 5'd31; data_pop = 10'd31;
    cyc; chk("stp31_d31", enable, 1'b0);
    data_pop = 10'd32;
    cyc; chk("stp31_d32", enable, 1'b1);

    instr = 8'h03; arg2 = 5'd0; data_pop = 10'd10;
    cyc; chk("evb0", enable, 1'b0);
    arg2 = 5'd5; data_pop = 10'd4;
    cyc; chk("evb5_d4", enable, 1'b0);
    data_pop = 10'd5;
    cyc; chk("evb5_d5", enable, 1'b1);

    instr = 8'h02; data_pop = 10'd0;
    cyc; chk("evp_d0", enable, 1'b0);
    data_pop = 10'd1;
    cyc; chk("evp_d1", enable, 1'b1);
    data_pop = 10'd0;
    instr = 8'h04;
    cyc; chk("rst_op", enable, 1'b1);
    instr = 8'h05;
    cyc; chk("hlt_op", enable, 1'b1);
    instr = 8'hFF;
    cyc; chk("inv_op", enable, 1'b1);

    next_instr = 2'b10;
    instr = 8'h02;
    free_space_out_result = 5'd1; free_space_out_status = 5'd0;
    cyc; chk("out_st0", enable, 1'b0);
    free_space_out_status = 5'd1;
    cyc; chk("out_ok", enable, 1'b1);
    free_space_out_result = 5'd0; free_space_out_status = 5'd5;
    cyc; chk("out_res0", enable, 1'b0);

    instr = 8'h03; arg2 = 5'd8;
    free_space_out_result = 5'd7; free_space_out_status = 5'd1;
    cyc; chk("outevb_r7", enable, 1'b0);
    free_space_out_result = 5'd8;
    cyc; chk("outevb_r8", enable, 1'b1);

    next_instr = 2'b11;
    command_pop = '1; data_pop = '1;
    free_space_out_result = '1; free_space_out_status = '1;
    cyc; chk("mode11", enable, 1'b0);

    next_instr = 2'b10;
    cyc; chk("pre_rst", enable, 1'b1);
    rst = 1'b1;
    cyc; chk("mid_rst", enable, 1'b0);
    rst = 1'b0;
    cyc; chk("post_rst", enable, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
